// File: rtl/vector_unpacker_if.sv
// Vector-in / beat-out bundle for the unpacker. Every transfer on either side
// happens on the clock edge where valid && ready; a source keeps valid and its payload stable until then.
interface vector_unpacker_if #(
   parameter int DATA_W    = 16,
   parameter int NUM_ELEM  = 64,
   parameter int OUT_LANES = 4
);
   logic [NUM_ELEM*DATA_W-1:0]  in_data;
   logic [6:0]                  in_count;
   logic                        in_valid;
   logic                        in_ready;
   logic [OUT_LANES*DATA_W-1:0] out_data;
   logic [OUT_LANES-1:0]        out_keep;
   logic                        out_last;
   logic                        out_valid;
   logic                        out_ready;
   logic                        busy;

   modport slave (
      input  in_data, in_count, in_valid, out_ready,
      output in_ready, out_data, out_keep, out_last, out_valid, busy
   );

   modport master (
      output in_data, in_count, in_valid, out_ready,
      input  in_ready, out_data, out_keep, out_last, out_valid, busy
   );
endinterface

// File: rtl/vector_unpacker.sv
// Captures one NUM_ELEM-element vector per handshake and replays it as
// OUT_LANES-wide beats with a lane mask and a last-beat flag.
module vector_unpacker #(
   parameter int DATA_W    = 16,
   parameter int NUM_ELEM  = 64,
   parameter int OUT_LANES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   vector_unpacker_if.slave  bus,
   output logic              dbg_state_o
);
   localparam int NUM_BEATS = NUM_ELEM / OUT_LANES;
   localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int VEC_W     = NUM_ELEM * DATA_W;
   localparam int OUT_W     = OUT_LANES * DATA_W;

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_e;

   state_e             state_q;
   logic [VEC_W-1:0]   buf_q;
   logic [6:0]         count_q;
   logic [BEAT_W-1:0]  beat_idx_q;
   logic               out_valid_q;
   logic [OUT_W-1:0]   out_data_q;
   logic [OUT_LANES-1:0] out_keep_q;
   logic               out_last_q;

   logic [6:0]         count_clamped;
   logic               accept;
   logic               beat_hs;
   logic               load;

   logic [VEC_W-1:0]     src_vec;
   logic [6:0]           src_cnt;
   int                   src_beat;
   int                   idx;
   logic [OUT_W-1:0]     beat_data_d;
   logic [OUT_LANES-1:0] beat_keep_d;
   logic                 beat_last_d;

   assign count_clamped = (int'(bus.in_count) > NUM_ELEM) ? 7'(NUM_ELEM) : bus.in_count;

   // A new vector can only land when idle or as the last beat leaves.
   assign bus.in_ready = (state_q == IDLE) || (bus.out_ready && out_last_q);
   assign accept       = bus.in_valid && bus.in_ready;
   assign beat_hs      = out_valid_q && bus.out_ready;
   assign load         = accept && (count_clamped != 7'd0);

   // Contents of the beat that becomes visible after this edge.
   always_comb begin
      src_vec     = load ? bus.in_data : buf_q;
      src_cnt     = load ? count_clamped : count_q;
      src_beat    = load ? 0 : int'(beat_idx_q) + 1;
      idx         = 0;
      beat_data_d = '0;
      beat_keep_d = '0;
      for (int j = 0; j < OUT_LANES; j++) begin
         idx = src_beat * OUT_LANES + j;
         if (idx < int'(src_cnt)) begin
            beat_data_d[j*DATA_W +: DATA_W] = src_vec[idx*DATA_W +: DATA_W];
            beat_keep_d[j]                  = 1'b1;
         end
      end
      beat_last_d = ((src_beat + 1) * OUT_LANES) >= int'(src_cnt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         buf_q       <= '0;
         count_q     <= '0;
         beat_idx_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         if (accept) begin
            buf_q      <= bus.in_data;
            count_q    <= count_clamped;
            beat_idx_q <= '0;
         end else if (beat_hs && !out_last_q) begin
            beat_idx_q <= beat_idx_q + BEAT_W'(1);
         end

         case (state_q)
            IDLE: begin
               if (load) begin
                  state_q     <= STREAM;
                  out_valid_q <= 1'b1;
                  out_data_q  <= beat_data_d;
                  out_keep_q  <= beat_keep_d;
                  out_last_q  <= beat_last_d;
               end
            end
            STREAM: begin
               if (beat_hs) begin
                  if (!out_last_q || load) begin
                     out_data_q <= beat_data_d;
                     out_keep_q <= beat_keep_d;
                     out_last_q <= beat_last_d;
                  end else begin
                     state_q     <= IDLE;
                     out_valid_q <= 1'b0;
                     out_data_q  <= '0;
                     out_keep_q  <= '0;
                     out_last_q  <= 1'b0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_keep  = out_keep_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = (state_q == STREAM);
   assign dbg_state_o   = (state_q == STREAM);
endmodule

// File: tb/tb_vector_unpacker.sv
// Bench for vector_unpacker: directed scenarios with literal checks plus a
// random phase, all compared every cycle against a queue-of-beats model.
module tb_vector_unpacker;
   localparam int DW = 16;
   localparam int NE = 64;
   localparam int L  = 4;
   localparam int VW = NE * DW;
   localparam int OW = L * DW;

   typedef struct {
      logic [OW-1:0] data;
      logic [L-1:0]  keep;
      logic          last;
   } beat_t;

   logic clk;
   logic rst_n;
   logic dbg_state;

   vector_unpacker_if #(.DATA_W(DW), .NUM_ELEM(NE), .OUT_LANES(L)) bus_if ();

   vector_unpacker #(.DATA_W(DW), .NUM_ELEM(NE), .OUT_LANES(L)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_if),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int    total = 0;
   int    bad   = 0;
   int    delivered = 0;
   beat_t exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // The model: a vector is just a list of beats, each built by chunking the element list.
   function automatic void push_vec(input logic [VW-1:0] v, input logic [6:0] c);
      int    cnt;
      int    nb;
      int    e;
      beat_t t;
      cnt = (int'(c) > NE) ? NE : int'(c);
      nb  = (cnt + L - 1) / L;
      for (int b = 0; b < nb; b++) begin
         t.data = '0;
         t.keep = '0;
         for (int j = 0; j < L; j++) begin
            e = b * L + j;
            if (e < cnt) begin
               t.data[j*DW +: DW] = v[e*DW +: DW];
               t.keep[j]          = 1'b1;
            end
         end
         t.last = (b == nb - 1);
         exp_q.push_back(t);
      end
   endfunction

   always @(negedge rst_n) exp_q.delete();

   always @(posedge clk) begin : model_update
      logic rdy;
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         rdy = (exp_q.size() == 0) || (bus_if.out_ready && exp_q.size() == 1);
         if (exp_q.size() > 0 && bus_if.out_ready) void'(exp_q.pop_front());
         if (bus_if.in_valid && rdy) push_vec(bus_if.in_data, bus_if.in_count);
      end
   end

   logic          hold;
   logic [OW-1:0] hold_data;
   logic [L-1:0]  hold_keep;
   logic          hold_last;

   always @(negedge clk) begin : compare
      beat_t f;
      logic  ev;
      logic  eir;
      if (!rst_n) begin
         chk("rst_out_valid", bus_if.out_valid, 0);
         chk("rst_in_ready",  bus_if.in_ready, 1);
         chk("rst_busy",      bus_if.busy, 0);
         chk("rst_out_last",  bus_if.out_last, 0);
         chk("rst_out_keep",  bus_if.out_keep, 0);
         chk("rst_out_data",  bus_if.out_data, 0);
         hold = 1'b0;
      end else begin
         ev  = exp_q.size() > 0;
         eir = !ev || (bus_if.out_ready && exp_q.size() == 1);
         chk("out_valid", bus_if.out_valid, ev);
         chk("in_ready",  bus_if.in_ready, eir);
         chk("busy",      bus_if.busy, ev);
         chk("dbg_state", dbg_state, ev);
         if (ev) begin
            f = exp_q[0];
            chk("out_data", bus_if.out_data, f.data);
            chk("out_keep", bus_if.out_keep, f.keep);
            chk("out_last", bus_if.out_last, f.last);
         end
         if (hold) begin
            chk("stall_valid", bus_if.out_valid, 1);
            chk("stall_data",  bus_if.out_data, hold_data);
            chk("stall_keep",  bus_if.out_keep, hold_keep);
            chk("stall_last",  bus_if.out_last, hold_last);
         end
         hold      = bus_if.out_valid && !bus_if.out_ready;
         hold_data = bus_if.out_data;
         hold_keep = bus_if.out_keep;
         hold_last = bus_if.out_last;
         if (bus_if.out_valid && bus_if.out_ready) delivered += $countones(bus_if.out_keep);
      end
   end

   // ---------------- driver ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_vec(output logic [VW-1:0] v);
      for (int i = 0; i < NE; i++) v[i*DW +: DW] = 16'($urandom);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin
         cyc();
         n++;
      end
      cyc();
      chk(name, n < 200, 1);
   endtask

   logic [VW-1:0] v;
   logic [1:0]    pat;

   initial begin
      rst_n            = 1'b0;
      bus_if.in_data   = '0;
      bus_if.in_count  = '0;
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();

      // Full vector, element i = 0x1000+i.
      for (int i = 0; i < NE; i++) v[i*DW +: DW] = 16'h1000 + 16'(i);
      bus_if.in_data   = v;
      bus_if.in_count  = 7'd64;
      bus_if.in_valid  = 1'b1;
      bus_if.out_ready = 1'b1;
      cyc();
      bus_if.in_valid = 1'b0;
      chk("full_b0_valid", bus_if.out_valid, 1);
      chk("full_b0_data",  bus_if.out_data, 64'h1003_1002_1001_1000);
      chk("full_b0_keep",  bus_if.out_keep, 4'hF);
      chk("full_b0_last",  bus_if.out_last, 0);
      repeat (14) cyc();
      chk("full_b14_last", bus_if.out_last, 0);
      cyc();
      chk("full_b15_data", bus_if.out_data, 64'h103F_103E_103D_103C);
      chk("full_b15_last", bus_if.out_last, 1);
      cyc();
      chk("full_done_valid", bus_if.out_valid, 0);

      // Partial vector, count=6.
      rand_vec(v);
      bus_if.in_data  = v;
      bus_if.in_count = 7'd6;
      bus_if.in_valid = 1'b1;
      cyc();
      bus_if.in_valid = 1'b0;
      chk("part_b0_keep", bus_if.out_keep, 4'hF);
      cyc();
      chk("part_b1_keep", bus_if.out_keep, 4'b0011);
      chk("part_b1_hi",   bus_if.out_data[63:32], 0);
      chk("part_b1_lo",   bus_if.out_data[31:0], {v[5*DW +: DW], v[4*DW +: DW]});
      chk("part_b1_last", bus_if.out_last, 1);
      cyc();

      // Zero count is consumed and dropped.
      bus_if.in_count = 7'd0;
      bus_if.in_valid = 1'b1;
      cyc();
      bus_if.in_valid = 1'b0;
      chk("zero_valid",    bus_if.out_valid, 0);
      chk("zero_busy",     bus_if.busy, 0);
      chk("zero_in_ready", bus_if.in_ready, 1);
      cyc();

      // Back-to-back count=8 vectors.
      for (int i = 0; i < NE; i++) v[i*DW +: DW] = 16'hA000 + 16'(i);
      bus_if.in_data  = v;
      bus_if.in_count = 7'd8;
      bus_if.in_valid = 1'b1;
      cyc();
      for (int i = 0; i < NE; i++) v[i*DW +: DW] = 16'hB000 + 16'(i);
      bus_if.in_data = v;
      chk("b2b_a0_valid", bus_if.out_valid, 1);
      chk("b2b_a0_data",  bus_if.out_data, 64'hA003_A002_A001_A000);
      cyc();
      chk("b2b_a1_valid",    bus_if.out_valid, 1);
      chk("b2b_a1_last",     bus_if.out_last, 1);
      chk("b2b_a1_in_ready", bus_if.in_ready, 1);
      cyc();
      bus_if.in_valid = 1'b0;
      chk("b2b_b0_valid", bus_if.out_valid, 1);
      chk("b2b_b0_data",  bus_if.out_data, 64'hB003_B002_B001_B000);
      cyc();
      chk("b2b_b1_valid", bus_if.out_valid, 1);
      chk("b2b_b1_data",  bus_if.out_data, 64'hB007_B006_B005_B004);
      cyc();
      chk("b2b_done_valid", bus_if.out_valid, 0);

      // Backpressure 1,0,0,1 on a full vector.
      rand_vec(v);
      bus_if.in_data  = v;
      bus_if.in_count = 7'd64;
      bus_if.in_valid = 1'b1;
      cyc();
      bus_if.in_valid = 1'b0;
      delivered = 0;
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
         pat = 2'(k % 4);
         bus_if.out_ready = (pat == 2'd0) || (pat == 2'd3);
         cyc();
      end
      drain("bp_drain");
      chk("bp_delivered", delivered, 64);

      // Reset in the middle of a vector.
      rand_vec(v);
      bus_if.in_data  = v;
      bus_if.in_count = 7'd64;
      bus_if.in_valid = 1'b1;
      cyc();
      bus_if.in_valid = 1'b0;
      repeat (4) cyc();
      rst_n = 1'b0;
      #1;
      chk("mrst_valid",    bus_if.out_valid, 0);
      chk("mrst_busy",     bus_if.busy, 0);
      chk("mrst_in_ready", bus_if.in_ready, 1);
      cyc();
      rst_n = 1'b1;
      rand_vec(v);
      bus_if.in_data  = v;
      bus_if.in_count = 7'd5;
      bus_if.in_valid = 1'b1;
      cyc();
      bus_if.in_valid = 1'b0;
      chk("mrst_new_b0", bus_if.out_data, v[63:0]);
      cyc();
      chk("mrst_new_b1_keep", bus_if.out_keep, 4'b0001);
      chk("mrst_new_b1_last", bus_if.out_last, 1);
      cyc();

      // Random traffic, including counts above NUM_ELEM.
      for (int k = 0; k < 500; k++) begin
         rand_vec(v);
         bus_if.in_data = v;
         case ($urandom_range(0, 3))
            0:       bus_if.in_count = 7'd0;
            1:       bus_if.in_count = 7'($urandom_range(65, 127));
            default: bus_if.in_count = 7'($urandom_range(1, 64));
         endcase
         bus_if.in_valid  = ($urandom_range(0, 3) != 0);
         bus_if.out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      drain("rand_drain");
      chk("end_busy", bus_if.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
